// File: rtl/enc_pkg.sv
// Shared definitions for the AES encryption sequencer and its datapath mux.
package enc_pkg;

  localparam logic [1:0] SEL_ARK = 2'b00;
  localparam logic [1:0] SEL_SB  = 2'b01;
  localparam logic [1:0] SEL_MC  = 2'b10;
  localparam logic [1:0] SEL_SR  = 2'b11;

  localparam int unsigned AES128_ROUNDS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARK0,
    ST_SB,
    ST_SR,
    ST_MC,
    ST_ARK,
    ST_DONE
  } enc_state_t;

endpackage

// File: rtl/enc_round_counter.sv
// 4-bit AES round counter: synchronous clear, saturating increment, at-max flag.
module enc_round_counter
  import enc_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] count,
  output logic       at_max
);

  assign at_max = (count == 4'(NUM_ROUNDS));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/encryption_controller.sv
// AES encryption round sequencer with Moore outputs driving the stage mux.
// Optional abort input enabled by defining ENC_CTRL_ABORT_EN.
module encryption_controller
  import enc_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
`ifdef ENC_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic [1:0] process_output,
  output logic       load_state,
  output logic       sel_plaintext,
  output logic [3:0] round_num,
  output logic       busy,
  output logic       done
);

  enc_state_t state, state_next;
  logic [3:0] count;
  logic       at_max;
  logic       cnt_clear;
  logic       cnt_inc;
  logic       abort_req;

`ifdef ENC_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  enc_round_counter #(
    .NUM_ROUNDS(NUM_ROUNDS)
  ) u_round_counter (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .count (count),
    .at_max(at_max)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    process_output = SEL_ARK;
    load_state     = 1'b0;
    sel_plaintext  = 1'b0;
    round_num      = '0;
    busy           = 1'b0;
    done           = 1'b0;
    cnt_clear      = 1'b0;
    cnt_inc        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        cnt_clear = 1'b1;
        if (start && !abort_req) state_next = ST_ARK0;
      end
      ST_ARK0: begin
        process_output = SEL_ARK;
        sel_plaintext  = 1'b1;
        load_state     = 1'b1;
        busy           = 1'b1;
        cnt_inc        = 1'b1;
        state_next     = ST_SB;
      end
      ST_SB: begin
        process_output = SEL_SB;
        load_state     = 1'b1;
        busy           = 1'b1;
        state_next     = ST_SR;
      end
      ST_SR: begin
        process_output = SEL_SR;
        load_state     = 1'b1;
        busy           = 1'b1;
        // the final round skips MixColumns
        state_next     = at_max ? ST_ARK : ST_MC;
      end
      ST_MC: begin
        process_output = SEL_MC;
        load_state     = 1'b1;
        busy           = 1'b1;
        state_next     = ST_ARK;
      end
      ST_ARK: begin
        process_output = SEL_ARK;
        round_num      = count;
        load_state     = 1'b1;
        busy           = 1'b1;
        if (at_max) begin
          state_next = ST_DONE;
        end else begin
          cnt_inc    = 1'b1;
          state_next = ST_SB;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        cnt_clear  = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (abort_req && busy) begin
      state_next = ST_IDLE;
      cnt_clear  = 1'b1;
      cnt_inc    = 1'b0;
    end
  end

endmodule

// File: tb/tb_encryption_controller.sv
// Self-checking bench: per-cycle expected output words built from the AES round order.
module tb_encryption_controller;

  localparam int unsigned N = 10;

  logic       clk   = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
`ifdef ENC_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [1:0] process_output;
  logic       load_state;
  logic       sel_plaintext;
  logic [3:0] round_num;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  encryption_controller #(
    .NUM_ROUNDS(N)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .start         (start),
`ifdef ENC_CTRL_ABORT_EN
    .abort         (abort),
`endif
    .process_output(process_output),
    .load_state    (load_state),
    .sel_plaintext (sel_plaintext),
    .round_num     (round_num),
    .busy          (busy),
    .done          (done)
  );

  // word layout: {sel[9:8], load[7], plaintext[6], round[5:2], busy[1], done[0]}
  typedef struct packed {
    logic [9:0] w;
    logic [9:0] m;
  } exp_t;

  localparam logic [9:0] M_FULL = 10'h3FF;
  localparam logic [9:0] M_MID  = 10'h3C3;
  localparam logic [9:0] M_DONE = 10'h083;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   late_mc = 0;
  bit   seen_last = 1'b0;
  int   ark0_cyc = -1;
  int   prev_ark0 = -1;
  exp_t q[$];

  function automatic logic [9:0] mk(input logic [1:0] sel, input logic ld, input logic pt,
                                    input logic [3:0] rn, input logic b, input logic d);
    return {sel, ld, pt, rn, b, d};
  endfunction

  function automatic logic [9:0] obs_word();
    return {process_output, load_state, sel_plaintext, round_num, busy, done};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic build_block();
    q.delete();
    q.push_back('{mk(2'b00, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0), M_FULL});
    for (int r = 1; r <= int'(N); r++) begin
      q.push_back('{mk(2'b01, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0), M_MID});
      q.push_back('{mk(2'b11, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0), M_MID});
      if (r < int'(N)) q.push_back('{mk(2'b10, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0), M_MID});
      q.push_back('{mk(2'b00, 1'b1, 1'b0, 4'(r), 1'b1, 1'b0), M_FULL});
    end
    q.push_back('{mk(2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1), M_DONE});
  endtask

  task automatic cmp(input string tag, input exp_t e);
    logic [9:0] o;
    o = obs_word();
    check_eq(tag, 32'(o & e.m), 32'(e.w & e.m));
    if (busy && sel_plaintext) begin
      seen_last = 1'b0;
      prev_ark0 = ark0_cyc;
      ark0_cyc  = cyc;
    end
    if (seen_last && process_output == 2'b10) late_mc++;
    if (busy && !sel_plaintext && process_output == 2'b00 && round_num == 4'(N - 1)) seen_last = 1'b1;
  endtask

  task automatic cmp_idle(input string tag);
    cmp(tag, '{mk(2'b00, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0), M_FULL});
  endtask

  task automatic run_queue(input string tag, input bit rand_start, input bit hold);
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      cmp(tag, e);
      if (rand_start) start = 1'($urandom_range(0, 1));
      else start = hold;
      tick();
    end
  endtask

  task automatic launch(input int gap);
    start = 1'b0;
    for (int i = 0; i < gap; i++) begin
      cmp_idle("gap_idle");
      tick();
    end
    start = 1'b1;
    tick();
  endtask

  initial begin
    #2;
    cmp_idle("reset_at_t0");
    #5 n_rst = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      cmp_idle("idle_no_start");
      tick();
    end

    // randomized gaps and ignored start re-pulses during busy
    for (int b = 0; b < 3; b++) begin
      late_mc = 0;
      launch($urandom_range(0, 4));
      build_block();
      run_queue("block", 1'b1, 1'b0);
      start = 1'b0;
      cmp_idle("post_done_idle");
      check_eq("no_final_mc", 32'(late_mc), 32'd0);
      tick();
    end

    // start held high continuously: next ARK0 42 cycles after the previous
    launch(1);
    build_block();
    run_queue("held", 1'b0, 1'b1);
    cmp_idle("held_idle_gap");
    tick();
    build_block();
    cmp("held_second_ark0", q.pop_front());
    check_eq("ark0_period", 32'(ark0_cyc - prev_ark0), 32'd42);
    start = 1'b0;
    tick();
    run_queue("held_rest", 1'b0, 1'b0);

    // asynchronous reset in the middle of a block
    launch(2);
    build_block();
    start = 1'b0;
    for (int i = 0; i < 19; i++) begin
      cmp("pre_reset", q.pop_front());
      tick();
    end
    cmp("pre_reset", q.pop_front());
    #2 n_rst = 1'b0;
    #1;
    cmp_idle("async_reset_now");
    tick();
    cmp_idle("reset_held");
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp_idle("after_reset_no_done");
    end
    launch(0);
    build_block();
    run_queue("after_reset_block", 1'b0, 1'b0);
    cmp_idle("after_reset_idle");

`ifdef ENC_CTRL_ABORT_EN
    launch(1);
    build_block();
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cmp("pre_abort", q.pop_front());
      tick();
    end
    cmp("pre_abort", q.pop_front());
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cmp_idle("abort_to_idle");
    abort = 1'b1;
    start = 1'b1;
    tick();
    cmp_idle("abort_beats_start");
    abort = 1'b0;
    start = 1'b0;
    tick();
    cmp_idle("abort_idle_hold");
    launch(0);
    build_block();
    run_queue("after_abort_block", 1'b0, 1'b0);
    cmp_idle("after_abort_idle");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
